// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg -- shared definitions for the two-requester stack arbiter.
//   op_e   : operation encoding carried on a_op / b_op (push = 1, pop = 0)
//   id_e   : requester identity used for last-grant tracking and rsp_id
//   rr_pick: round-robin tie-break, returns the requester to favour
package stack_arb_pkg;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_e;

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } id_e;

    // On a tie the requester that was not granted most recently wins.
    function automatic id_e rr_pick(input id_e last_gnt);
        return (last_gnt == ID_A) ? ID_B : ID_A;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// stack_mem -- 2**DEPTH x WIDTH storage for the shared stack.
//   clk, reset_n : clock and async active-low reset (read register only;
//                  the array itself is never cleared)
//   we, waddr, wdata : synchronous write port
//   re, raddr        : read request; rdata updates on the following edge
//   rdata            : registered read data, holds its value between reads
module stack_mem #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter -- shares one LIFO stack between requesters A and B.
//   clk, reset_n          : clock, async active-low reset
//   a_req/a_op/a_wdata    : requester A operation (op 1 = push, 0 = pop)
//   a_gnt                 : A accepted this cycle (combinational)
//   b_req/b_op/b_wdata/b_gnt : same for requester B
//   rsp_valid/rsp_id/rsp_data : pop response, one cycle after the grant
//   count, full, empty    : stack occupancy and guards
//   high_water            : peak occupancy since reset, present only when
//                           the STACK_ARB_STATS_EN macro is defined
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_req,
    input  logic             a_op,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    input  logic             b_req,
    input  logic             b_op,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [DEPTH:0]   count,
`ifdef STACK_ARB_STATS_EN
    output logic [DEPTH:0]   high_water,
`endif
    output logic             full,
    output logic             empty
);

    localparam logic [DEPTH:0] CAPACITY = {1'b1, {DEPTH{1'b0}}};

    id_e              last_gnt;
    id_e              winner;
    logic             a_elig;
    logic             b_elig;
    logic             push_go;
    logic             pop_go;
    logic [WIDTH-1:0] push_data;
    logic [DEPTH-1:0] waddr;
    logic [DEPTH-1:0] raddr;

    assign full  = (count == CAPACITY);
    assign empty = (count == '0);

    // Arbitration: eligibility is gated by full/empty so an ineligible
    // request never wins and simply waits with gnt low.
    always_comb begin
        a_elig    = '0;
        b_elig    = '0;
        winner    = rr_pick(last_gnt);
        a_gnt     = '0;
        b_gnt     = '0;
        push_go   = '0;
        pop_go    = '0;
        push_data = a_wdata;

        a_elig = a_req && ((a_op == OP_PUSH) ? !full : !empty);
        b_elig = b_req && ((b_op == OP_PUSH) ? !full : !empty);

        a_gnt = a_elig && (!b_elig || (winner == ID_A));
        b_gnt = b_elig && (!a_elig || (winner == ID_B));

        if (a_gnt) begin
            push_go   = (a_op == OP_PUSH);
            pop_go    = (a_op == OP_POP);
            push_data = a_wdata;
        end else if (b_gnt) begin
            push_go   = (b_op == OP_PUSH);
            pop_go    = (b_op == OP_POP);
            push_data = b_wdata;
        end
    end

    // count doubles as the stack pointer; its low bits address the next
    // free slot, and low bits minus one address the top entry.
    assign waddr = count[DEPTH-1:0];
    assign raddr = count[DEPTH-1:0] - 1'b1;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (push_go),
        .waddr   (waddr),
        .wdata   (push_data),
        .re      (pop_go),
        .raddr   (raddr),
        .rdata   (rsp_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            last_gnt  <= ID_B;
            rsp_valid <= 1'b0;
            rsp_id    <= ID_A;
        end else begin
            rsp_valid <= pop_go;
            if (push_go) begin
                count <= count + 1'b1;
            end else if (pop_go) begin
                count <= count - 1'b1;
            end
            if (a_gnt) begin
                last_gnt <= ID_A;
            end else if (b_gnt) begin
                last_gnt <= ID_B;
            end
            if (pop_go) begin
                rsp_id <= b_gnt ? ID_B : ID_A;
            end
        end
    end

`ifdef STACK_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_water <= '0;
        end else if (push_go && ((count + 1'b1) > high_water)) begin
            high_water <= count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter -- directed, table-driven bench for stack_arbiter
// (WIDTH 11, DEPTH 7). Define STACK_ARB_STATS_EN to also check high_water.
module tb_stack_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_req, a_op, b_req, b_op;
    logic [10:0] a_wdata, b_wdata;
    logic        a_gnt, b_gnt;
    logic        rsp_valid, rsp_id;
    logic [10:0] rsp_data;
    logic [7:0]  count;
    logic        full, empty;
`ifdef STACK_ARB_STATS_EN
    logic [7:0]  high_water;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stack_arbiter #(
        .WIDTH (11),
        .DEPTH (7)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .a_req     (a_req),
        .a_op      (a_op),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .b_req     (b_req),
        .b_op      (b_op),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .count     (count),
`ifdef STACK_ARB_STATS_EN
        .high_water(high_water),
`endif
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        logic        ar;
        logic        ao;
        logic [10:0] ad;
        logic        br;
        logic        bo;
        logic [10:0] bd;
        logic        eag;
        logic        ebg;
        logic        ev;
        logic        eid;
        logic [10:0] edata;
        logic [7:0]  ecnt;
    } vec_t;

    localparam int unsigned NVEC = 15;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ar, input logic ao, input logic [10:0] ad,
                         input logic br, input logic bo, input logic [10:0] bd);
        a_req = ar; a_op = ao; a_wdata = ad;
        b_req = br; b_op = bo; b_wdata = bd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            ar ao  ad      br bo  bd      ag bg v  id data    cnt
        tbl[0]  = '{1, 1, 11'h155, 0, 0, 11'h000, 1, 0, 0, 0, 11'h000, 8'd1};
        tbl[1]  = '{1, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1, 0, 11'h155, 8'd0};
        tbl[2]  = '{0, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0, 0, 11'h000, 8'd0};
        tbl[3]  = '{1, 1, 11'h001, 1, 1, 11'h101, 0, 1, 0, 0, 11'h000, 8'd1};
        tbl[4]  = '{1, 1, 11'h001, 1, 1, 11'h102, 1, 0, 0, 0, 11'h000, 8'd2};
        tbl[5]  = '{1, 1, 11'h002, 1, 1, 11'h102, 0, 1, 0, 0, 11'h000, 8'd3};
        tbl[6]  = '{1, 1, 11'h002, 0, 0, 11'h000, 1, 0, 0, 0, 11'h000, 8'd4};
        tbl[7]  = '{1, 0, 11'h000, 1, 0, 11'h000, 0, 1, 1, 1, 11'h002, 8'd3};
        tbl[8]  = '{1, 0, 11'h000, 1, 0, 11'h000, 1, 0, 1, 0, 11'h102, 8'd2};
        tbl[9]  = '{1, 0, 11'h000, 1, 0, 11'h000, 0, 1, 1, 1, 11'h001, 8'd1};
        tbl[10] = '{1, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1, 0, 11'h101, 8'd0};
        tbl[11] = '{1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0, 0, 11'h000, 8'd0};
        tbl[12] = '{1, 0, 11'h000, 0, 0, 11'h000, 0, 0, 0, 0, 11'h000, 8'd0};
        tbl[13] = '{1, 0, 11'h000, 1, 1, 11'h7FF, 0, 1, 0, 0, 11'h000, 8'd1};
        tbl[14] = '{1, 0, 11'h000, 0, 0, 11'h000, 1, 0, 1, 0, 11'h7FF, 8'd0};

        reset_n = 1'b0;
        drive(0, 0, '0, 0, 0, '0);
        #3;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
`ifdef STACK_ARB_STATS_EN
        chk("reset_high_water", 32'(high_water), 32'd0);
`endif
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].ar, tbl[i].ao, tbl[i].ad, tbl[i].br, tbl[i].bo, tbl[i].bd);
            #1;
            chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(tbl[i].eag));
            chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(tbl[i].ebg));
            tick();
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(tbl[i].eid));
                chk($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(tbl[i].edata));
            end
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
            chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].ecnt == 8'd0));
        end
        drive(0, 0, '0, 0, 0, '0);
        tick();
        chk("pulse_one_cycle", 32'(rsp_valid), 32'd0);

        // Fill to capacity with B, word i at slot i.
        for (int i = 0; i < 128; i++) begin
            drive(0, 0, '0, 1, 1, 11'(i));
            tick();
        end
        chk("fill_count", 32'(count), 32'd128);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);

        // Full: A push stalls while B pop proceeds, then A push lands.
        drive(1, 1, 11'h3AA, 1, 0, '0);
        #1;
        chk("full_a_gnt", 32'(a_gnt), 32'd0);
        chk("full_b_gnt", 32'(b_gnt), 32'd1);
        tick();
        chk("full_pop_valid", 32'(rsp_valid), 32'd1);
        chk("full_pop_id", 32'(rsp_id), 32'd1);
        chk("full_pop_data", 32'(rsp_data), 32'h07F);
        chk("full_pop_count", 32'(count), 32'd127);
        drive(1, 1, 11'h3AA, 0, 0, '0);
        #1;
        chk("full_retry_a_gnt", 32'(a_gnt), 32'd1);
        tick();
        chk("full_retry_count", 32'(count), 32'd128);
        chk("full_retry_full", 32'(full), 32'd1);

        // Reset while a pop response is in flight.
        drive(0, 0, '0, 1, 0, '0);
        #1;
        chk("inflight_b_gnt", 32'(b_gnt), 32'd1);
        tick();
        drive(0, 0, '0, 0, 0, '0);
        chk("inflight_valid", 32'(rsp_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(rsp_valid), 32'd0);
        chk("midreset_count", 32'(count), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("postreset_empty", 32'(empty), 32'd1);
        chk("postreset_count", 32'(count), 32'd0);
        chk("postreset_valid", 32'(rsp_valid), 32'd0);

        // Push 10, pop 6, push 3.
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 11'(i + 16), 0, 0, '0);
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, '0, 0, 0, '0);
            tick();
        end
        chk("stats_last_pop_data", 32'(rsp_data), 32'd20);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 11'(i + 64), 0, 0, '0);
            tick();
        end
        drive(0, 0, '0, 0, 0, '0);
        chk("stats_count", 32'(count), 32'd7);
`ifdef STACK_ARB_STATS_EN
        chk("stats_high_water", 32'(high_water), 32'd10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
